// File: rtl/priority_encoder_seq.sv
// Registered priority encoder with a one-entry valid/ready output stage.
// The multi-hot error check is built only when ENC_MULTIHOT_CHECK_EN is defined.
module priority_encoder_seq #(
    parameter  int N    = 8,
    parameter  int MODE = 0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         none,
    output logic         err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_y;
    logic           r_none;
    logic [W-1:0]   r_ptr;

    logic           w_accept;
    logic           w_none;
    logic [N-1:0]   w_mask;
    logic [N-1:0]   w_hi;
    logic [N-1:0]   w_sel;
    logic [W-1:0]   w_idx;
    logic [W-1:0]   w_next;

    assign in_ready  = (r_state == EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_none    = ~|req;
    assign out_valid = (r_state == FULL);
    assign y         = r_y;
    assign none      = r_none;

    // Round-robin: search bits at or above ptr first, then fall back to the
    // lowest set bit overall, which is the wrap-around part of the search.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (MODE == 1) ? (i >= int'(r_ptr)) : 1'b1;
        end
        w_hi  = req & w_mask;
        w_sel = (|w_hi) ? w_hi : req;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_idx = W'(i);
            end
        end
    end

    assign w_next = (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);

`ifdef ENC_MULTIHOT_CHECK_EN
    logic r_err;
    logic w_multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(req & (req - N'(1)));
    assign err     = r_err;
`else
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_y     <= '0;
            r_none  <= 1'b0;
            r_ptr   <= '0;
`ifdef ENC_MULTIHOT_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_state <= FULL;
                r_y     <= w_idx;
                r_none  <= w_none;
`ifdef ENC_MULTIHOT_CHECK_EN
                r_err   <= w_multi;
`endif
                if ((MODE == 1) && !w_none) begin
                    r_ptr <= w_next;
                end
            end else if (out_ready) begin
                r_state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed-vector bench: fixed-priority, round-robin and 5-input round-robin
// instances share one stimulus stream and are checked against hand-computed values.
module tb_priority_encoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] req = 8'h00;

    logic       ir0, ov0, none0, err0;
    logic [2:0] y0;
    logic       ir1, ov1, none1, err1;
    logic [2:0] y1;
    logic       ir2, ov2, none2, err2;
    logic [2:0] y2;

    int total = 0;
    int bad   = 0;

`ifdef ENC_MULTIHOT_CHECK_EN
    localparam logic EXP_MH = 1'b1;
`else
    localparam logic EXP_MH = 1'b0;
`endif

    always #5 clk = ~clk;

    priority_encoder_seq #(.N(8), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .req(req),
        .out_valid(ov0), .out_ready(out_ready), .y(y0), .none(none0), .err(err0)
    );

    priority_encoder_seq #(.N(8), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .req(req),
        .out_valid(ov1), .out_ready(out_ready), .y(y1), .none(none1), .err(err1)
    );

    priority_encoder_seq #(.N(5), .MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .req(req[4:0]),
        .out_valid(ov2), .out_ready(out_ready), .y(y2), .none(none2), .err(err2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        req       = 8'h00;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({ov0, ov1, ov2} !== 3'b000) begin
            bad++; $display("FAIL reset_out_valid got=%b exp=000", {ov0, ov1, ov2});
        end
        total++;
        if ({y0, y1, y2} !== 9'd0) begin
            bad++; $display("FAIL reset_y got=%h/%h/%h exp=0/0/0", y0, y1, y2);
        end
        total++;
        if ({none0, none1, none2, err0, err1, err2} !== 6'b0) begin
            bad++; $display("FAIL reset_none_err got=%b exp=000000",
                            {none0, none1, none2, err0, err1, err2});
        end
        total++;
        if ({ir0, ir1, ir2} !== 3'b111) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=111", {ir0, ir1, ir2});
        end
    endtask

    task automatic test_fixed;
        logic [7:0] vec [4] = '{8'h24, 8'h80, 8'hA0, 8'h01};
        logic [2:0] ex  [4] = '{3'd2, 3'd7, 3'd5, 3'd0};
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = vec[i];
            tick();
            total++;
            if (ov0 !== 1'b1 || y0 !== ex[i] || none0 !== 1'b0) begin
                bad++; $display("FAIL fixed_%0d req=%h got v=%b y=%0d n=%b exp v=1 y=%0d n=0",
                                i, vec[i], ov0, y0, none0, ex[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (ov0 !== 1'b0) begin
            bad++; $display("FAIL fixed_drain got out_valid=%b exp=0", ov0);
        end
    endtask

    task automatic test_rr;
        logic [7:0] vec [4] = '{8'h01, 8'h82, 8'h82, 8'h82};
        logic [2:0] ex  [4] = '{3'd0, 3'd1, 3'd7, 3'd1};
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        req       = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (ov1 !== 1'b1 || y1 !== 3'(i % 8)) begin
                bad++; $display("FAIL rr_wrap_%0d got v=%b y=%0d exp v=1 y=%0d", i, ov1, y1, i % 8);
            end
        end
        for (int i = 0; i < 4; i++) begin
            req = vec[i];
            tick();
            total++;
            if (y1 !== ex[i]) begin
                bad++; $display("FAIL rr_seq_%0d req=%h got y=%0d exp y=%0d", i, vec[i], y1, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        req       = 8'h24;
        tick();
        total++;
        if (ov0 !== 1'b1 || y0 !== 3'd2 || y1 !== 3'd2) begin
            bad++; $display("FAIL bp_first got v=%b y0=%0d y1=%0d exp v=1 y0=2 y1=2", ov0, y0, y1);
        end
        req = 8'h80;
        total++;
        if (ir0 !== 1'b0 || ir1 !== 1'b0) begin
            bad++; $display("FAIL bp_in_ready got=%b%b exp=00", ir0, ir1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ov0 !== 1'b1 || y0 !== 3'd2 || y1 !== 3'd2 || ir0 !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got v=%b y0=%0d y1=%0d rdy=%b exp v=1 y0=2 y1=2 rdy=0",
                                i, ov0, y0, y1, ir0);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (ir0 !== 1'b1 || ir1 !== 1'b1) begin
            bad++; $display("FAIL bp_release_ready got=%b%b exp=11", ir0, ir1);
        end
        tick();
        total++;
        if (ov0 !== 1'b1 || y0 !== 3'd7 || y1 !== 3'd7) begin
            bad++; $display("FAIL bp_next got v=%b y0=%0d y1=%0d exp v=1 y0=7 y1=7", ov0, y0, y1);
        end
    endtask

    task automatic test_zero;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        req       = 8'h00;
        tick();
        total++;
        if (ov0 !== 1'b1 || y0 !== 3'd0 || none0 !== 1'b1 || y1 !== 3'd0 || none1 !== 1'b1) begin
            bad++; $display("FAIL zero_none got v=%b y0=%0d n0=%b y1=%0d n1=%b exp v=1 y0=0 n0=1 y1=0 n1=1",
                            ov0, y0, none0, y1, none1);
        end
        req = 8'hFF;
        tick();
        total++;
        if (y1 !== 3'd0 || none1 !== 1'b0) begin
            bad++; $display("FAIL zero_ptr_kept got y=%0d n=%b exp y=0 n=0", y1, none1);
        end
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        total++;
        if (none1 !== 1'b1 || y1 !== 3'd0) begin
            bad++; $display("FAIL zero_second got y=%0d n=%b exp y=0 n=1", y1, none1);
        end
        req = 8'hFF;
        tick();
        total++;
        if (y1 !== 3'd3) begin
            bad++; $display("FAIL zero_ptr_after got y=%0d exp y=3", y1);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        req       = 8'h10;
        tick();
        total++;
        if (ov1 !== 1'b1 || y1 !== 3'd4) begin
            bad++; $display("FAIL rstmid_full got v=%b y=%0d exp v=1 y=4", ov1, y1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ov1 !== 1'b0 || ov0 !== 1'b0 || y1 !== 3'd0 || none1 !== 1'b0) begin
            bad++; $display("FAIL rstmid_async got v1=%b v0=%b y=%0d n=%b exp v1=0 v0=0 y=0 n=0",
                            ov1, ov0, y1, none1);
        end
        tick();
        rst_n     = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;
        tick();
        total++;
        if (ov1 !== 1'b1 || y1 !== 3'd0) begin
            bad++; $display("FAIL rstmid_ptr0 got v=%b y=%0d exp v=1 y=0", ov1, y1);
        end
    endtask

    task automatic test_multihot;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        req       = 8'h18;
        tick();
        total++;
        if (y0 !== 3'd3 || y1 !== 3'd3) begin
            bad++; $display("FAIL mh_y got y0=%0d y1=%0d exp 3/3", y0, y1);
        end
        total++;
        if (err0 !== EXP_MH || err1 !== EXP_MH) begin
            bad++; $display("FAIL mh_err got=%b%b exp=%b%b", err0, err1, EXP_MH, EXP_MH);
        end
        req = 8'h08;
        tick();
        total++;
        if (err0 !== 1'b0 || y0 !== 3'd3) begin
            bad++; $display("FAIL mh_single got err=%b y=%0d exp err=0 y=3", err0, y0);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_non_pow2;
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        req       = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (ov2 !== 1'b1 || y2 !== 3'(i % 5)) begin
                bad++; $display("FAIL np2_wrap_%0d got v=%b y=%0d exp v=1 y=%0d", i, ov2, y2, i % 5);
            end
        end
        req = 8'h10;
        tick();
        total++;
        if (y2 !== 3'd4) begin
            bad++; $display("FAIL np2_top got y=%0d exp y=4", y2);
        end
        req = 8'h11;
        tick();
        total++;
        if (y2 !== 3'd0) begin
            bad++; $display("FAIL np2_wrap_ptr got y=%0d exp y=0", y2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fixed();
        test_rr();
        test_back_to_back();
        test_zero();
        test_reset_mid();
        test_multihot();
        test_non_pow2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
PRIORITY_ENCODER_SEQ -- requirements
Module: priority_encoder_seq

Interface
REQ-001 SHALL have parameter N, default 8: number of request inputs, N >= 2.
REQ-002 SHALL have parameter MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin rotating priority.
REQ-003 SHALL have localparam W = $clog2(N): index width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: req vector valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a req vector this cycle.
REQ-008 SHALL have port req, input, N bits: request vector.
REQ-009 SHALL have port out_valid, output, 1 bit: encoded result valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port y, output, W bits: encoded winning index.
REQ-012 SHALL have port none, output, 1 bit: the accepted req vector was all-zero.
REQ-013 SHALL have port err, output, 1 bit: the accepted req vector had more than one bit set.

Function
REQ-014 SHALL use a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational).
REQ-016 SHALL accept when in_valid && in_ready, and SHALL present the result on y/none/err with out_valid=1 on the next cycle (latency 1).
REQ-017 SHALL transition EMPTY->FULL on accept, FULL->EMPTY on out_ready without accept, and stay FULL on simultaneous out_ready and accept, with the register loaded with the new result.
REQ-018 SHALL hold y/none/err stable while out_valid && !out_ready.
REQ-019 SHALL, in MODE 0, select the lowest set index of req.
REQ-020 SHALL, in MODE 1, search from pointer ptr (W bits) upward, wrapping from N-1 to 0, and select the first set bit.
REQ-021 SHALL, in MODE 1 on accept with nonzero req, update ptr to (winner+1) mod N, wrapping from N-1 to 0.
REQ-022 SHALL leave ptr unchanged when the accepted req is all-zero or no accept occurs.
REQ-023 SHALL, for an all-zero req, produce y=0 and none=1; otherwise none=0.
REQ-024 SHALL behave correctly for non-power-of-2 N, with y never exceeding N-1.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force out_valid=0, y=0, none=0, err=0, ptr=0 and state EMPTY.
REQ-026 SHALL discard any pending result on reset mid-operation; the first accept after release uses ptr=0.

Configuration
REQ-027 SHALL use macro ENC_MULTIHOT_CHECK_EN to enable the multi-hot check.
REQ-028 SHALL, when ENC_MULTIHOT_CHECK_EN is defined, register err=1 with the result when popcount(req)>1, and set err=0 otherwise.
REQ-029 SHALL, when ENC_MULTIHOT_CHECK_EN is undefined, keep port err present and tie it to constant 0, with no check logic synthesised.
REQ-030 SHALL keep encode and priority behaviour identical in both builds.

Verification
REQ-031 SHALL cover: N=8 MODE 0, req=8'b0010_0100, out_ready=1 -> next cycle out_valid=1, y=2, none=0.
REQ-032 SHALL cover: N=8 MODE 1, req=8'hFF on 9 consecutive accepts -> y = 0,1,...,7,0 (pointer wrap).
REQ-033 SHALL cover: out_ready=0 after accept -> in_ready=0, y held 3 cycles; then out_ready=1 with new req=8'h80 -> back-to-back, y=7 next cycle.
REQ-034 SHALL cover: req=8'h00 -> y=0, none=1; MODE 1 ptr unchanged, so the next req=8'hFF gives y=0 after reset.
REQ-035 SHALL cover: rst_n low while FULL -> out_valid=0 immediately (asynchronous), ptr=0.
REQ-036 SHALL cover: req=8'b0001_1000 -> err=1 with macro defined, err=0 without; y=3 in both builds.
